// File: rtl/cordic_freq_disc.sv
// -----------------------------------------------------------------------------
// cordic_freq_disc
//
// Frequency discriminator placed behind a CORDIC vectoring pipeline. Tracks
// sample validity through the CORDIC latency, forms the wrapped phase step
// between consecutive samples (instantaneous frequency) with magnitude squelch,
// averages frequency and magnitude over 2^DECIM_LOG2 samples and queues the
// window results in a small FIFO behind a valid/ready handshake.
//
// Ports:
//   clock        single clock shared with the CORDIC
//   reset        asynchronous, active-high; clears all state
//   in_valid     high in the cycle x_start/y_start enter the CORDIC
//   magnitude    signed CORDIC magnitude (WIDTH bits)
//   phase        signed Q1.31 CORDIC phase (angle/pi)
//   mag_thresh   signed squelch threshold, quasi-static
//   out_valid    result FIFO is non-empty
//   out_ready    consumer accepts the head entry
//   freq_out     signed Q1.31 mean phase step per sample (0 when empty)
//   mag_out      signed mean magnitude over the window (0 when empty)
//   squelch_out  some sample in the window was below threshold (0 when empty)
//   overflow     sticky: a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module cordic_freq_disc #(
    parameter int WIDTH      = 16,
    parameter int LATENCY    = 17,
    parameter int DECIM_LOG2 = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] magnitude,
    input  logic [31:0]      phase,
    input  logic [WIDTH-1:0] mag_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      freq_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             squelch_out,
    output logic             overflow
);

    localparam int N    = 1 << DECIM_LOG2;
    localparam int CW   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int AFW  = 32 + DECIM_LOG2;
    localparam int AMW  = WIDTH + DECIM_LOG2;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int EW   = 1 + WIDTH + 32;

    // ---------------------------------------------------------------- valid pipe
    // The CORDIC has no reset; its outputs are only trusted while s_valid is high.
    logic [LATENCY-1:0] vpipe_q;
    logic               s_valid;

    assign s_valid = vpipe_q[LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= {vpipe_q[LATENCY-2:0], in_valid};
        end
    end

    // ---------------------------------------------------------------- stage A
    logic             a_valid_q;
    logic [31:0]      a_dphi_q;
    logic [WIDTH-1:0] a_mag_q;
    logic             a_sq_q;
    logic [31:0]      prev_phase_q;
    logic             have_prev_q;
    logic             mag_ok;

    assign mag_ok = $signed(magnitude) >= $signed(mag_thresh);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid_q    <= 1'b0;
            a_dphi_q     <= '0;
            a_mag_q      <= '0;
            a_sq_q       <= 1'b0;
            prev_phase_q <= '0;
            have_prev_q  <= 1'b0;
        end else begin
            a_valid_q <= s_valid;
            if (s_valid) begin
                a_mag_q <= magnitude;
                if (mag_ok) begin
                    // Plain 32-bit subtraction gives the wrap across +/-pi for free.
                    a_dphi_q     <= have_prev_q ? (phase - prev_phase_q) : '0;
                    prev_phase_q <= phase;
                    have_prev_q  <= 1'b1;
                    a_sq_q       <= 1'b0;
                end else begin
                    // A squelched sample breaks the phase history.
                    a_dphi_q    <= '0;
                    have_prev_q <= 1'b0;
                    a_sq_q      <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage B
    logic [AFW-1:0]   acc_f_q;
    logic [AMW-1:0]   acc_m_q;
    logic             win_sq_q;
    logic [CW-1:0]    cnt_q;
    logic [AFW-1:0]   sum_f_d;
    logic [AMW-1:0]   sum_m_d;
    logic             res_valid_q;
    logic [31:0]      res_freq_q;
    logic [WIDTH-1:0] res_mag_q;
    logic             res_sq_q;

    always_comb begin
        sum_f_d = acc_f_q + AFW'($signed(a_dphi_q));
        sum_m_d = acc_m_q + AMW'($signed(a_mag_q));
    end

    // The window result is registered once more before entering the FIFO so the
    // divide-by-shift and the FIFO write are in separate cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_f_q     <= '0;
            acc_m_q     <= '0;
            win_sq_q    <= 1'b0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_freq_q  <= '0;
            res_mag_q   <= '0;
            res_sq_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (a_valid_q) begin
                if (cnt_q == CW'(N - 1)) begin
                    // Arithmetic shift of the full-width sum, truncated.
                    res_valid_q <= 1'b1;
                    res_freq_q  <= sum_f_d[AFW-1:DECIM_LOG2];
                    res_mag_q   <= sum_m_d[AMW-1:DECIM_LOG2];
                    res_sq_q    <= win_sq_q | a_sq_q;
                    acc_f_q     <= '0;
                    acc_m_q     <= '0;
                    win_sq_q    <= 1'b0;
                    cnt_q       <= '0;
                end else begin
                    acc_f_q  <= sum_f_d;
                    acc_m_q  <= sum_m_d;
                    win_sq_q <= win_sq_q | a_sq_q;
                    cnt_q    <= cnt_q + CW'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- result FIFO
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PTRW-1:0] wptr_q;
    logic [PTRW-1:0] rptr_q;
    logic [PTRW:0]   fcnt_q;
    logic            overflow_q;
    logic            empty;
    logic            full;
    logic            rd_en;
    logic            wr_en;
    logic [EW-1:0]   head;

    assign empty = (fcnt_q == '0);
    assign full  = (fcnt_q == (PTRW+1)'(FIFO_DEPTH));
    assign rd_en = !empty && out_ready;
    // A full FIFO still accepts a write when the head is leaving this cycle.
    assign wr_en = res_valid_q && (!full || rd_en);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {res_sq_q, res_mag_q, res_freq_q};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PTRW'(1);
            end
            if (rd_en) begin
                rptr_q <= rptr_q + PTRW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fcnt_q <= fcnt_q + (PTRW+1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (PTRW+1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
            if (res_valid_q && full && !rd_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        head = mem_q[rptr_q];
        if (empty) begin
            head = '0;
        end
        {squelch_out, mag_out, freq_out} = head;
    end

    assign out_valid = !empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cordic_freq_disc.sv
module tb_cordic_freq_disc;

    localparam int W     = 16;
    localparam int L     = 17;
    localparam int D     = 3;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  magnitude;
    logic [31:0]   phase;
    logic [W-1:0]  mag_thresh;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   freq_out;
    logic [W-1:0]  mag_out;
    logic          squelch_out;
    logic          overflow;

    cordic_freq_disc #(
        .WIDTH      (W),
        .LATENCY    (L),
        .DECIM_LOG2 (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .magnitude   (magnitude),
        .phase       (phase),
        .mag_thresh  (mag_thresh),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .freq_out    (freq_out),
        .mag_out     (mag_out),
        .squelch_out (squelch_out),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct { logic v; logic [15:0] m; logic [31:0] p; } smp_t;
    typedef struct { longint due; logic [31:0] f; logic [15:0] m; logic sq; } res_t;
    typedef struct {
        logic [31:0]       ph0;
        logic [31:0]       step;
        logic [15:0]       mag;
        int                sq_idx;
        logic [2:0][31:0]  ef;
        logic [2:0][15:0]  em;
        logic [2:0]        es;
    } vec_t;

    smp_t        dq[$];      // samples waiting for their CORDIC delay
    res_t        pend[$];    // window results not yet due at the FIFO
    res_t        fq[$];      // reference FIFO contents
    logic [48:0] cap[$];     // entries the bench consumed from the DUT
    vec_t        vt[4];

    int          n_checks = 0;
    int          n_err    = 0;
    longint      edge_no  = 0;
    logic        rdy      = 1'b0;

    logic [31:0] m_prev;
    logic        m_have;
    longint      m_sf;
    longint      m_sm;
    logic        m_sq;
    int          m_n;
    logic        m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        dq.delete();
        pend.delete();
        fq.delete();
        m_prev = '0;
        m_have = 1'b0;
        m_sf   = 0;
        m_sm   = 0;
        m_sq   = 1'b0;
        m_n    = 0;
        m_ovf  = 1'b0;
    endtask

    // One sample, in order of arrival; the result becomes due at the FIFO on edge 'due'.
    task automatic model_sample(input logic [15:0] m, input logic [31:0] p, input longint due);
        logic [31:0] d;
        logic        sq;
        res_t        r;
        if ($signed(m) >= $signed(mag_thresh)) begin
            d      = m_have ? (p - m_prev) : 32'd0;
            m_prev = p;
            m_have = 1'b1;
            sq     = 1'b0;
        end else begin
            d      = 32'd0;
            m_have = 1'b0;
            sq     = 1'b1;
        end
        m_sf = m_sf + longint'($signed(d));
        m_sm = m_sm + longint'($signed(m));
        m_sq = m_sq | sq;
        m_n++;
        if (m_n == N) begin
            r.due = due;
            r.f   = 32'(m_sf >>> D);
            r.m   = 16'(m_sm >>> D);
            r.sq  = m_sq;
            pend.push_back(r);
            m_sf = 0;
            m_sm = 0;
            m_sq = 1'b0;
            m_n  = 0;
        end
    endtask

    task automatic model_edge(input logic rd_req);
        logic rd;
        logic wr;
        logic full_b;
        res_t r;
        res_t gone;
        rd     = (fq.size() > 0) && rd_req;
        full_b = (fq.size() == DEPTH);
        wr     = (pend.size() > 0) && (pend[0].due == edge_no);
        if (rd) gone = fq.pop_front();
        if (wr) begin
            r = pend.pop_front();
            if (full_b && !rd) m_ovf = 1'b1;
            else fq.push_back(r);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ef;
        logic [15:0] em;
        logic        es;
        ef = '0;
        em = '0;
        es = 1'b0;
        if (fq.size() > 0) begin
            ef = fq[0].f;
            em = fq[0].m;
            es = fq[0].sq;
        end
        chk("out_valid",   64'(out_valid),   64'(fq.size() > 0));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("freq_out",    64'(freq_out),    64'(ef));
        chk("mag_out",     64'(mag_out),     64'(em));
        chk("squelch_out", 64'(squelch_out), 64'(es));
    endtask

    // One clock cycle: present in_valid now, and the CORDIC outputs for the
    // sample issued L cycles ago (random garbage if there was none).
    task automatic cycle(input logic iv, input logic [15:0] m, input logic [31:0] p);
        smp_t s;
        smp_t o;
        in_valid = iv;
        out_ready = rdy;
        s.v = iv;
        s.m = m;
        s.p = p;
        dq.push_back(s);
        o.v = 1'b0;
        o.m = '0;
        o.p = '0;
        if (dq.size() > L) o = dq.pop_front();
        if (o.v) begin
            magnitude = o.m;
            phase     = o.p;
        end else begin
            magnitude = 16'($urandom);
            phase     = $urandom;
        end
        if (iv) model_sample(m, p, edge_no + 1 + L + 2);
        if (out_valid && out_ready) cap.push_back({squelch_out, mag_out, freq_out});
        @(posedge clock);
        edge_no++;
        model_edge(out_ready);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 16'd0, 32'd0);
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks it acts at once.
    task automatic reset_async();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        model_clear();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        @(posedge clock);
        edge_no++;
        @(posedge clock);
        edge_no++;
        #1;
        reset = 1'b0;
    endtask

    task automatic run_windows(input int nwin, input logic [31:0] ph0, input logic [31:0] step,
                               input int mag_base, input int mag_inc);
        for (int w = 0; w < nwin; w++) begin
            for (int i = 0; i < N; i++) begin
                cycle(1'b1, 16'(mag_base + mag_inc * w), ph0 + 32'(w * N + i) * step);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ph;
        logic [15:0] mg;
        longint      last_edge;
        int          first;
        int          lat;

        // Directed windows; expectations worked out by hand from the averaging rule.
        vt[0].ph0 = 32'h0000_0000; vt[0].step = 32'h1000_0000; vt[0].mag = 16'd1000; vt[0].sq_idx = -1;
        vt[0].ef[0] = 32'h0E00_0000; vt[0].ef[1] = 32'h1000_0000; vt[0].ef[2] = 32'h1000_0000;
        vt[0].em[0] = 16'd1000; vt[0].em[1] = 16'd1000; vt[0].em[2] = 16'd1000; vt[0].es = 3'b000;

        vt[1].ph0 = 32'h7000_0000; vt[1].step = 32'h2000_0000; vt[1].mag = 16'd1000; vt[1].sq_idx = -1;
        vt[1].ef[0] = 32'h1C00_0000; vt[1].ef[1] = 32'h2000_0000; vt[1].ef[2] = 32'h2000_0000;
        vt[1].em[0] = 16'd1000; vt[1].em[1] = 16'd1000; vt[1].em[2] = 16'd1000; vt[1].es = 3'b000;

        vt[2].ph0 = 32'h0000_0000; vt[2].step = 32'h1000_0000; vt[2].mag = 16'd1000; vt[2].sq_idx = 12;
        vt[2].ef[0] = 32'h0E00_0000; vt[2].ef[1] = 32'h0C00_0000; vt[2].ef[2] = 32'h1000_0000;
        vt[2].em[0] = 16'd1000; vt[2].em[1] = 16'd881; vt[2].em[2] = 16'd1000; vt[2].es = 3'b010;

        vt[3].ph0 = 32'h0500_0000; vt[3].step = 32'hFF00_0000; vt[3].mag = 16'd777; vt[3].sq_idx = -1;
        vt[3].ef[0] = 32'hFF20_0000; vt[3].ef[1] = 32'hFF00_0000; vt[3].ef[2] = 32'hFF00_0000;
        vt[3].em[0] = 16'd777; vt[3].em[1] = 16'd777; vt[3].em[2] = 16'd777; vt[3].es = 3'b000;

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        magnitude  = '0;
        phase      = '0;
        mag_thresh = 16'd100;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_valid",   64'(out_valid),   64'd0);
        chk("reset_overflow",    64'(overflow),    64'd0);
        chk("reset_freq_out",    64'(freq_out),    64'd0);
        chk("reset_mag_out",     64'(mag_out),     64'd0);
        chk("reset_squelch_out", 64'(squelch_out), 64'd0);
        reset = 1'b0;

        // Table: rotation, wrap, squelch, negative rotation.
        for (int t = 0; t < 4; t++) begin
            reset_async();
            rdy = 1'b1;
            cap.delete();
            for (int i = 0; i < 3 * N; i++) begin
                ph = vt[t].ph0 + 32'(i) * vt[t].step;
                mg = (i == vt[t].sq_idx) ? 16'd50 : vt[t].mag;
                cycle(1'b1, mg, ph);
            end
            repeat (L + 6) idle();
            chk("tbl_count", 64'(cap.size()), 64'd3);
            for (int w = 0; w < 3 && w < cap.size(); w++) begin
                chk("tbl_freq", 64'(cap[w][31:0]),  64'(vt[t].ef[w]));
                chk("tbl_mag",  64'(cap[w][47:32]), 64'(vt[t].em[w]));
                chk("tbl_sq",   64'(cap[w][48]),    64'(vt[t].es[w]));
            end
        end

        // Backpressure: 5 windows into a 4-deep FIFO, last one dropped.
        reset_async();
        rdy = 1'b0;
        cap.delete();
        run_windows(5, 32'h0, 32'h1000_0000, 300, 100);
        repeat (L + 4) idle();
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_overflow",  64'(overflow),  64'd1);
        rdy = 1'b1;
        repeat (6) idle();
        rdy = 1'b0;
        chk("bp_count", 64'(cap.size()), 64'd4);
        for (int k = 0; k < 4 && k < cap.size(); k++)
            chk("bp_order", 64'(cap[k][47:32]), 64'(300 + 100 * k));
        chk("bp_overflow_sticky", 64'(overflow), 64'd1);

        // Same, but read exactly in the fifth result's write cycle.
        reset_async();
        rdy = 1'b0;
        cap.delete();
        run_windows(5, 32'h0, 32'h1000_0000, 300, 100);
        last_edge = edge_no;
        for (int n = 0; n < L + 4; n++) begin
            rdy = (edge_no + 1 == last_edge + L + 2);
            idle();
        end
        rdy = 1'b0;
        chk("pulse_overflow",  64'(overflow),  64'd0);
        chk("pulse_out_valid", 64'(out_valid), 64'd1);
        rdy = 1'b1;
        repeat (6) idle();
        chk("pulse_count", 64'(cap.size()), 64'd5);
        for (int k = 0; k < 5 && k < cap.size(); k++)
            chk("pulse_order", 64'(cap[k][47:32]), 64'(300 + 100 * k));

        // Reset mid-window with a full, overflowed FIFO.
        reset_async();
        rdy = 1'b0;
        run_windows(5, 32'h0, 32'h0300_0000, 500, 0);
        repeat (L + 4) idle();
        chk("mid_pre_out_valid", 64'(out_valid), 64'd1);
        chk("mid_pre_overflow",  64'(overflow),  64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'd1000, 32'h1234_0000 * 32'(i + 1));
        reset_async();
        rdy = 1'b1;
        cap.delete();
        for (int i = 0; i < N - 1; i++) cycle(1'b1, 16'd1000, 32'h4000_0000 + 32'(i) * 32'h1000_0000);
        repeat (L + 4) idle();
        chk("mid_no_early", 64'(cap.size()), 64'd0);
        cycle(1'b1, 16'd1000, 32'h4000_0000 + 32'(N - 1) * 32'h1000_0000);
        repeat (L + 4) idle();
        chk("mid_count", 64'(cap.size()), 64'd1);
        if (cap.size() > 0) chk("mid_freq", 64'(cap[0][31:0]), 64'h0E00_0000);

        // Latency with random gaps between the 8 samples.
        reset_async();
        rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 16'd1000, 32'(i) * 32'h0100_0000);
            if (i != N - 1) begin
                lat = $urandom_range(0, 3);
                repeat (lat) idle();
            end
        end
        first = 0;
        for (int n = 1; n <= 40 && first == 0; n++) begin
            idle();
            if (out_valid) first = n;
        end
        chk("latency", 64'(first), 64'(L + 2));

        // Random traffic against the reference model.
        reset_async();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7)
                cycle(1'b1, 16'($urandom_range(0, 400)) - 16'd50, $urandom);
            else
                idle();
        end
        rdy = 1'b1;
        repeat (L + 10) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
